// File: rtl/uart.sv
// Full-duplex 8-bit UART, optional odd/even parity, DIV = CLK_FREQ/BAUD clocks per bit.
// TX accepts a send only while idle (no queue); RX reports each good frame with a one-cycle rx_ok.
module uart #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int PARITY   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_send,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ok,
    output logic       rx_error
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shr_q, tx_shr_d;
    logic          tx_par;

    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shr_q, rx_shr_d;
    logic          rx_par_q, rx_par_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_err_q, rx_err_d;
    logic          rx_ok_q, rx_ok_d;
    logic          rx_s1_q, rx_s2_q;
    logic          rx_exp_par;

    assign tx_par     = (PARITY == 1) ? ~^tx_shr_q : ^tx_shr_q;
    assign rx_exp_par = (PARITY == 1) ? ~^rx_shr_q : ^rx_shr_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_cnt_q == DIV_M1) ? '0 : tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_shr_d   = tx_shr_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (tx_send) begin
                    tx_shr_d   = tx_data;
                    tx_idx_d   = 3'd0;
                    tx_state_d = S_START;
                end
            end
            S_START: if (tx_cnt_q == DIV_M1) tx_state_d = S_DATA;
            S_DATA: if (tx_cnt_q == DIV_M1) begin
                tx_idx_d = tx_idx_q + 3'd1;
                if (tx_idx_q == 3'd7) tx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR:  if (tx_cnt_q == DIV_M1) tx_state_d = S_STOP;
            S_STOP: if (tx_cnt_q == DIV_M1) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (tx_state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shr_q[tx_idx_q];
            S_PAR:   tx = tx_par;
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state_q != S_IDLE);

    // Every sample point restarts the counter, so each later sample lands DIV clocks after the last.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_shr_d   = rx_shr_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        rx_ok_d    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = '0;
                rx_idx_d   = 3'd0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d = '0;
                rx_shr_d = {rx_s2_q, rx_shr_q[7:1]};
                rx_idx_d = rx_idx_q + 3'd1;
                if (rx_idx_q == 3'd7) rx_state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_par_d   = rx_s2_q;
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d = '0;
                if (rx_s2_q) begin
                    rx_data_d  = rx_shr_q;
                    rx_err_d   = (PARITY != 0) && (rx_par_q != rx_exp_par);
                    rx_ok_d    = 1'b1;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                rx_cnt_d = '0;
                if (rx_s2_q) rx_state_d = S_IDLE;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shr_q   <= 8'h00;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_shr_q   <= 8'h00;
            rx_par_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_err_q   <= 1'b0;
            rx_ok_q    <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shr_q   <= tx_shr_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shr_q   <= rx_shr_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            rx_ok_q    <= rx_ok_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_error = rx_err_q;
    assign rx_ok    = rx_ok_q;
endmodule

// File: tb/tb_uart.sv
// Directed bench: default-rate UART without parity, plus fast odd- and even-parity instances.
module tb_uart;
    localparam int BIT0 = 434 * 20;   // default DUT: 434 clocks of 20 time units
    localparam int BIT1 = 16 * 20;    // fast DUTs: 16 clocks per bit

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] tx_data0 = 8'h00, tx_data1 = 8'h00, tx_data2 = 8'h00;
    logic       tx_send0 = 1'b0, tx_send1 = 1'b0, tx_send2 = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic       tx0, tx1, tx2, busy0, busy1, busy2;
    logic [7:0] rxd0, rxd1, rxd2;
    logic       rxok0, rxok1, rxok2, rxerr0, rxerr1, rxerr2;

    int vectors = 0;
    int miscompares = 0;
    int ok_cnt0 = 0, ok_cnt1 = 0, ok_cnt2 = 0;
    logic [7:0] log_d2 [0:31];
    logic       log_e2 [0:31];

    uart u0 (.clk(clk), .rst(rst), .tx_data(tx_data0), .tx_send(tx_send0), .tx(tx0), .tx_busy(busy0),
             .rx(rx0), .rx_data(rxd0), .rx_ok(rxok0), .rx_error(rxerr0));
    uart #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(1)) u1 (
             .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_send(tx_send1), .tx(tx1), .tx_busy(busy1),
             .rx(rx1), .rx_data(rxd1), .rx_ok(rxok1), .rx_error(rxerr1));
    uart #(.CLK_FREQ(1_600_000), .BAUD(100_000), .PARITY(2)) u2 (
             .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_send(tx_send2), .tx(tx2), .tx_busy(busy2),
             .rx(rx2), .rx_data(rxd2), .rx_ok(rxok2), .rx_error(rxerr2));

    always @(posedge clk) begin
        if (rxok0) ok_cnt0 <= ok_cnt0 + 1;
        if (rxok1) ok_cnt1 <= ok_cnt1 + 1;
        if (rxok2) begin
            if (ok_cnt2 < 32) begin
                log_d2[ok_cnt2] <= rxd2;
                log_e2[ok_cnt2] <= rxerr2;
            end
            ok_cnt2 <= ok_cnt2 + 1;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // par < 0 means no parity bit; line is left high afterwards.
    task automatic drive_frame(input int inst, input logic [7:0] d, input int par,
                               input logic stop, input int bit_t);
        set_rx(inst, 1'b0);
        #(bit_t);
        for (int b = 0; b < 8; b++) begin
            set_rx(inst, d[b]);
            #(bit_t);
        end
        if (par >= 0) begin
            set_rx(inst, par[0]);
            #(bit_t);
        end
        set_rx(inst, stop);
        #(bit_t);
        set_rx(inst, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (tx0 !== 1'b1) begin miscompares++; $display("FAIL reset_tx0 got %b want 1", tx0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy0 got %b want 0", busy0); end
        vectors++; if (rxd0 !== 8'h00) begin miscompares++; $display("FAIL reset_rxd0 got %h want 00", rxd0); end
        vectors++; if (rxok0 !== 1'b0) begin miscompares++; $display("FAIL reset_rxok0 got %b want 0", rxok0); end
        vectors++; if (rxerr0 !== 1'b0) begin miscompares++; $display("FAIL reset_rxerr0 got %b want 0", rxerr0); end
        vectors++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_u1 got tx=%b busy=%b want tx=1 busy=0", tx1, busy1); end
        vectors++; if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            miscompares++; $display("FAIL reset_u2 got tx=%b busy=%b want tx=1 busy=0", tx2, busy2); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tx_a5;
        logic [9:0] expv;
        logic       bad;
        logic       seen;
        int         busy_cnt;
        expv = {1'b1, 8'hA5, 1'b0};
        busy_cnt = 0;
        bad = 1'b0;
        seen = 1'b0;
        tx_data0 = 8'hA5; tx_send0 = 1'b1;
        @(negedge clk);
        tx_send0 = 1'b0;
        for (int i = 0; i < 4340; i++) begin
            if (tx0 !== expv[i / 434] && !bad) begin bad = 1'b1; seen = tx0; end
            if (busy0 === 1'b1) busy_cnt++;
            if (i % 434 == 433) begin
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL tx_a5_bit%0d got %b want %b (cycle %0d of bit)", i / 434, seen, expv[i / 434], i % 434);
                end
                bad = 1'b0;
            end
            // ignored request and mid-frame data change
            if (i == 1000) begin tx_data0 = 8'hFF; tx_send0 = 1'b1; end
            if (i == 1001) tx_send0 = 1'b0;
            @(negedge clk);
        end
        vectors++; if (busy_cnt !== 4340) begin miscompares++; $display("FAIL tx_a5_busy_len got %0d want 4340", busy_cnt); end
        vectors++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
            miscompares++; $display("FAIL tx_a5_end got busy=%b tx=%b want busy=0 tx=1", busy0, tx0); end
        repeat (5) @(negedge clk);
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL tx_ignored_send got busy=%b want 0", busy0); end
    endtask

    task automatic test_rx_3c;
        int base;
        base = ok_cnt0;
        drive_frame(0, 8'h3C, -1, 1'b1, BIT0);
        @(negedge clk);
        vectors++; if (ok_cnt0 - base !== 1) begin miscompares++; $display("FAIL rx_3c_okcnt got %0d want 1", ok_cnt0 - base); end
        vectors++; if (rxd0 !== 8'h3C) begin miscompares++; $display("FAIL rx_3c_data got %h want 3c", rxd0); end
        vectors++; if (rxerr0 !== 1'b0) begin miscompares++; $display("FAIL rx_3c_err got %b want 0", rxerr0); end
    endtask

    task automatic test_glitch;
        int base;
        base = ok_cnt0;
        rx0 = 1'b0;
        #2000;
        rx0 = 1'b1;
        #(3 * BIT0);
        @(negedge clk);
        vectors++; if (ok_cnt0 - base !== 0) begin miscompares++; $display("FAIL glitch_okcnt got %0d want 0", ok_cnt0 - base); end
        vectors++; if (rxd0 !== 8'h3C) begin miscompares++; $display("FAIL glitch_data got %h want 3c", rxd0); end
    endtask

    task automatic test_framing;
        int base;
        base = ok_cnt0;
        drive_frame(0, 8'h55, -1, 1'b0, BIT0);
        #(2 * BIT0);
        @(negedge clk);
        vectors++; if (ok_cnt0 - base !== 0) begin miscompares++; $display("FAIL frame_err_okcnt got %0d want 0", ok_cnt0 - base); end
        vectors++; if (rxd0 !== 8'h3C) begin miscompares++; $display("FAIL frame_err_data got %h want 3c", rxd0); end
        base = ok_cnt0;
        drive_frame(0, 8'h81, -1, 1'b1, BIT0);
        @(negedge clk);
        vectors++; if (ok_cnt0 - base !== 1) begin miscompares++; $display("FAIL frame_next_okcnt got %0d want 1", ok_cnt0 - base); end
        vectors++; if (rxd0 !== 8'h81) begin miscompares++; $display("FAIL frame_next_data got %h want 81", rxd0); end
    endtask

    task automatic test_parity_odd;
        logic [10:0] expv;
        int base;
        expv = {1'b1, 1'b0, 8'h01, 1'b0};
        tx_data1 = 8'h01; tx_send1 = 1'b1;
        @(negedge clk);
        tx_send1 = 1'b0;
        for (int i = 0; i < 176; i++) begin
            if (i % 16 == 8) begin
                vectors++;
                if (tx1 !== expv[i / 16]) begin
                    miscompares++; $display("FAIL odd_tx_bit%0d got %b want %b", i / 16, tx1, expv[i / 16]); end
            end
            @(negedge clk);
        end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL odd_tx_end got busy=%b want 0", busy1); end
        base = ok_cnt1;
        drive_frame(1, 8'h03, 0, 1'b1, BIT1);
        @(negedge clk);
        vectors++; if (ok_cnt1 - base !== 1) begin miscompares++; $display("FAIL odd_rx_bad_okcnt got %0d want 1", ok_cnt1 - base); end
        vectors++; if (rxd1 !== 8'h03) begin miscompares++; $display("FAIL odd_rx_bad_data got %h want 03", rxd1); end
        vectors++; if (rxerr1 !== 1'b1) begin miscompares++; $display("FAIL odd_rx_bad_err got %b want 1", rxerr1); end
        drive_frame(1, 8'h03, 1, 1'b1, BIT1);
        @(negedge clk);
        vectors++; if (rxerr1 !== 1'b0) begin miscompares++; $display("FAIL odd_rx_good_err got %b want 0", rxerr1); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] tb_b [20];
        logic [7:0] rb_b [20];
        int base;
        for (int k = 0; k < 20; k++) begin
            tb_b[k] = 8'($urandom_range(0, 255));
            rb_b[k] = 8'($urandom_range(0, 255));
        end
        base = ok_cnt2;
        fork
            begin : sender
                int t;
                for (int k = 0; k < 20; k++) begin
                    t = 0;
                    while (busy2 !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
                    tx_data2 = tb_b[k]; tx_send2 = 1'b1;
                    @(negedge clk);
                    tx_send2 = 1'b0; tx_data2 = ~tb_b[k];
                end
            end
            begin : decoder
                int t;
                logic [7:0] d;
                logic p, s;
                for (int k = 0; k < 20; k++) begin
                    t = 0;
                    while (tx2 !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
                    vectors++;
                    if (tx2 !== 1'b0) begin
                        miscompares++; $display("FAIL b2b_start%0d got no start bit want 0", k);
                        break;
                    end
                    repeat (8) @(negedge clk);
                    for (int b = 0; b < 8; b++) begin
                        repeat (16) @(negedge clk);
                        d[b] = tx2;
                    end
                    repeat (16) @(negedge clk); p = tx2;
                    repeat (16) @(negedge clk); s = tx2;
                    vectors++; if (d !== tb_b[k]) begin miscompares++; $display("FAIL b2b_tx_data%0d got %h want %h", k, d, tb_b[k]); end
                    vectors++; if (p !== ^tb_b[k] || s !== 1'b1) begin
                        miscompares++; $display("FAIL b2b_tx_par_stop%0d got %b%b want %b1", k, p, s, ^tb_b[k]); end
                end
            end
            begin : rx_driver
                for (int k = 0; k < 20; k++) drive_frame(2, rb_b[k], int'(^rb_b[k]), 1'b1, BIT1);
            end
        join
        repeat (4) @(negedge clk);
        vectors++; if (ok_cnt2 - base !== 20) begin miscompares++; $display("FAIL b2b_rx_okcnt got %0d want 20", ok_cnt2 - base); end
        for (int k = 0; k < 20 && base + k < 32; k++) begin
            vectors++;
            if (log_d2[base + k] !== rb_b[k] || log_e2[base + k] !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_rx%0d got %h err=%b want %h err=0", k, log_d2[base + k], log_e2[base + k], rb_b[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        base = ok_cnt0;
        tx_data0 = 8'hC3; tx_send0 = 1'b1;
        @(negedge clk);
        tx_send0 = 1'b0;
        fork
            drive_frame(0, 8'h5A, -1, 1'b1, BIT0);
            begin
                repeat (2000) @(negedge clk);
                vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_busy got %b want 1", busy0); end
                rst = 1'b1;
                @(negedge clk);
                vectors++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
                    miscompares++; $display("FAIL rstmid_tx got tx=%b busy=%b want tx=1 busy=0", tx0, busy0); end
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (ok_cnt0 - base !== 0) begin miscompares++; $display("FAIL rstmid_okcnt got %0d want 0", ok_cnt0 - base); end
        vectors++; if (rxd0 !== 8'h00 || busy0 !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_after got rxd=%h busy=%b want rxd=00 busy=0", rxd0, busy0); end
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_rx_3c();
        test_glitch();
        test_framing();
        test_parity_odd();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tx_data  input  8  byte to transmit, sampled when tx_send is accepted.
REQ-007 tx_send  input  1  one-cycle transmit request.
REQ-008 tx  output  1  serial transmit line, idle high.
REQ-009 tx_busy  output  1  high while a frame is in progress.
REQ-010 rx  input  1  serial receive line, asynchronous, idle high.
REQ-011 rx_data  output  8  last received byte.
REQ-012 rx_ok  output  1  one-cycle pulse, new byte on rx_data.
REQ-013 rx_error  output  1  parity error flag for the last byte; constant 0 when PARITY=0.

Function
REQ-014 Bit period SHALL be DIV = CLK_FREQ/BAUD clocks (integer division; 434 at defaults), with a free-running per-direction counter restarted at each frame start.
REQ-015 Frame SHALL be: start bit (0), 8 data bits LSB first, parity bit if PARITY!=0 (odd: XNOR-reduce of data; even: XOR-reduce), one stop bit (1).
REQ-016 TX states SHALL be IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
REQ-017 In IDLE with tx_send=1, the block SHALL latch tx_data and enter START; tx_busy SHALL be high and tx low from the next cycle.
REQ-018 Each TX state SHALL last exactly DIV clocks; DATA SHALL iterate over bits 0..7 with a 3-bit index.
REQ-019 tx_busy SHALL fall, and the FSM SHALL return to IDLE, on the cycle after the full stop-bit period; tx stays high.
REQ-020 tx_send while tx_busy=1 SHALL be ignored; no queueing. A change of tx_data mid-frame SHALL NOT affect the frame.
REQ-021 tx_send asserted on the cycle tx_busy falls SHALL be accepted, giving back-to-back frames.
REQ-022 rx SHALL pass through a two-flop synchronizer before any use.
REQ-023 RX states SHALL be IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
REQ-024 In IDLE, a synchronized low SHALL enter START; at DIV/2 the line SHALL be re-sampled; if high, the start is a glitch and the FSM SHALL return to IDLE.
REQ-025 Data, parity and stop bits SHALL be sampled once each at mid-bit, DIV clocks after the previous sample; data SHALL be shifted LSB first.
REQ-026 At the stop-bit sample, if the line is 1: rx_data SHALL be updated, rx_error set to the parity mismatch (0 if PARITY=0), rx_ok pulsed for exactly one clock, and the FSM SHALL return to IDLE.
REQ-027 At the stop-bit sample, if the line is 0 (framing error): no rx_ok, rx_data and rx_error unchanged, and the FSM SHALL wait for the line to go high before returning to IDLE.
REQ-028 rx_data and rx_error SHALL hold their values until the next valid frame.
REQ-029 TX and RX SHALL operate fully independently and concurrently (full duplex).

Reset
REQ-030 With rst high at a clock edge, both FSMs SHALL go to IDLE, counters to 0, tx=1, tx_busy=0, rx_data=8'h00, rx_ok=0, rx_error=0, and synchronizer flops to 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no rx_ok is produced for the aborted byte.

Verification
REQ-032 PARITY=0, pulse tx_send with tx_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 of 434 clocks each; tx_busy high for 4340 clocks.
REQ-033 PARITY=0, drive rx frame for 8'h3C at 8680 ns/bit -> rx_data=8'h3C, one-cycle rx_ok in the stop bit, rx_error=0.
REQ-034 PARITY=1, transmit 8'h01 -> parity bit 0; receive 8'h03 with parity bit 0 -> rx_ok pulse and rx_error=1.
REQ-035 PARITY=2, transmit 20 random bytes back-to-back with tx_send pulses while simultaneously receiving 20 random bytes -> all decoded bytes match, parity correct, stop bit high, no errors.
REQ-036 A 2 us low glitch on rx -> no rx_ok; a frame with stop bit 0 -> no rx_ok, and the next valid frame is received correctly.
REQ-037 rst asserted mid-TX frame -> tx=1 and tx_busy=0 on the next cycle; tx_send issued while busy -> ignored.
